// File: rtl/uart_rx_fifo.sv
// Byte FWFT FIFO between uart_rx and uart_debug; `define UART_RX_FIFO_XOFF_EN adds a hysteresis xoff flag.
// Latency: a pushed byte shows on out_data/out_valid one cycle after the push edge (no empty bypass).
// Backpressure: in_ready = !full, out_valid = !empty, both from registered pointers only.
module uart_rx_fifo #(
    parameter int DEPTH = 16,
    parameter int HI_WM = 12,
    parameter int LO_WM = 4
) (
    input  logic                       clk,
    input  logic                       reset_,
    input  logic                       flush,
    input  logic [7:0]                 in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [7:0]                 out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       xoff
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
        $error("uart_rx_fifo: DEPTH must be a power of two >= 2");
    end

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW-1:0] wr_ptr_nxt, rd_ptr_nxt;
    logic          empty, full, push, pop;

    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign out_data  = mem[rd_ptr[AW-1:0]];
    assign level     = wr_ptr - rd_ptr;

    // Flush wins over push/pop; reset wins over flush in the register block below.
    always_comb begin
        wr_ptr_nxt = wr_ptr;
        rd_ptr_nxt = rd_ptr;
        if (flush) begin
            wr_ptr_nxt = '0;
            rd_ptr_nxt = '0;
        end else begin
            if (push) wr_ptr_nxt = wr_ptr + PW'(1);
            if (pop)  rd_ptr_nxt = rd_ptr + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            wr_ptr <= wr_ptr_nxt;
            rd_ptr <= rd_ptr_nxt;
        end
    end

    // Storage is never cleared; a write during flush lands beyond the reset pointers and is unreachable.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= in_data;
    end

`ifdef UART_RX_FIFO_XOFF_EN
    if (!(LO_WM < HI_WM && HI_WM <= DEPTH)) begin : g_wm_chk
        $error("uart_rx_fifo: need LO_WM < HI_WM <= DEPTH");
    end

    logic [PW-1:0] level_nxt;
    assign level_nxt = wr_ptr_nxt - rd_ptr_nxt;

    always_ff @(posedge clk) begin
        if (!reset_) begin
            xoff <= 1'b0;
        end else if (level_nxt >= PW'(HI_WM)) begin
            xoff <= 1'b1;
        end else if (level_nxt <= PW'(LO_WM)) begin
            xoff <= 1'b0;
        end
    end
`else
    logic unused_wm;
    assign unused_wm = ^{HI_WM, LO_WM};
    assign xoff      = 1'b0;
`endif

endmodule
